// File: rtl/pim_metadata_loader_pkg.sv
// Shared definitions for the PIM metadata loader: FSM states, table geometry
// shared with pim_sparsity_aware and the firmware build, and the index-width helper.
package pim_meta_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_REQ   = 3'd1,
    ST_WAIT  = 3'd2,
    ST_WRITE = 3'd3,
    ST_DONE  = 3'd4,
    ST_ERROR = 3'd5
  } meta_state_e;

  localparam int          META_NUM_WORDS = 128;
  localparam logic [31:0] META_BASE_ADDR = 32'h0004_0000;

  function automatic int metaIdxWidth(input int numWords);
    return (numWords > 1) ? $clog2(numWords) : 1;
  endfunction

endpackage

// File: rtl/pim_metadata_loader_if.sv
// Memory read port and metadata-table write port seen by the loader.
// master = loader side, slave = memory/table side.
interface pim_metadata_loader_if
  import pim_meta_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int WORD_WIDTH = 32,
  parameter int NUM_WORDS  = META_NUM_WORDS
);
  localparam int IDX_W = metaIdxWidth(NUM_WORDS);

  logic                  mem_req_valid;
  logic                  mem_req_ready;
  logic [ADDR_WIDTH-1:0] mem_req_addr;
  logic                  mem_rsp_valid;
  logic [WORD_WIDTH-1:0] mem_rsp_data;
  logic                  meta_wr_en;
  logic [IDX_W-1:0]      meta_wr_idx;
  logic [WORD_WIDTH-1:0] meta_wr_data;

  modport master (
    output mem_req_valid, mem_req_addr, meta_wr_en, meta_wr_idx, meta_wr_data,
    input  mem_req_ready, mem_rsp_valid, mem_rsp_data
  );

  modport slave (
    input  mem_req_valid, mem_req_addr, meta_wr_en, meta_wr_idx, meta_wr_data,
    output mem_req_ready, mem_rsp_valid, mem_rsp_data
  );

endinterface

// File: rtl/pim_metadata_loader_timeout.sv
// Response-timeout counter: cleared when a request is accepted, counts idle
// WAIT cycles, and flags the last permitted cycle before the loader gives up.
module pim_meta_timeout #(
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic clk,
  input  logic rst,
  input  logic clear_i,
  input  logic count_i,
  output logic expired_o
);
  localparam int CNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

  logic [CNT_W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clear_i) begin
      count_d = '0;
    end else if (count_i) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign expired_o = (count_q == CNT_W'(TIMEOUT_CYC - 1));

endmodule

// File: rtl/pim_metadata_loader.sv
// Copies the sparsity metadata image from memory into the PIM metadata table,
// holding PIM compute meanwhile. Define PIM_META_CSUM_EN to add an XOR checksum read.
module pim_metadata_loader
  import pim_meta_pkg::*;
#(
  parameter int                    ADDR_WIDTH  = 32,
  parameter int                    WORD_WIDTH  = 32,
  parameter int                    NUM_WORDS   = META_NUM_WORDS,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR   = META_BASE_ADDR,
  parameter int                    TIMEOUT_CYC = 1024
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start_i,
  output logic                         busy_o,
  output logic                         done_o,
  output logic                         err_o,
  output logic                         pim_hold_o,
  pim_metadata_loader_if.master        metaBus
);
  localparam int               IDX_W    = metaIdxWidth(NUM_WORDS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_WORDS - 1);

  meta_state_e           state_q;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic                  busy_q, done_q, err_q;
  logic                  reqValid_q, wrEn_q;
  logic [ADDR_WIDTH-1:0] reqAddr_q;
  logic [WORD_WIDTH-1:0] wrData_q;
  logic                  toClear, toCount, toExpired;

`ifdef PIM_META_CSUM_EN
  localparam logic [ADDR_WIDTH-1:0] CSUM_ADDR = BASE_ADDR + ADDR_WIDTH'(4 * NUM_WORDS);
  logic [WORD_WIDTH-1:0] acc_q;
  logic                  csumPhase_q;
`endif

  assign idx_d = idx_q + 1'b1;

  assign toClear = (state_q == ST_REQ) && metaBus.mem_req_ready;
  assign toCount = (state_q == ST_WAIT) && !metaBus.mem_rsp_valid;

  pim_meta_timeout #(
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) u_timeout (
    .clk       (clk),
    .rst       (rst),
    .clear_i   (toClear),
    .count_i   (toCount),
    .expired_o (toExpired)
  );

  // Outputs are set on entry to the state that owns them, so each one is a plain flop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      idx_q      <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      reqValid_q <= 1'b0;
      reqAddr_q  <= '0;
      wrEn_q     <= 1'b0;
      wrData_q   <= '0;
`ifdef PIM_META_CSUM_EN
      acc_q       <= '0;
      csumPhase_q <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
      wrEn_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (start_i) begin
            state_q    <= ST_REQ;
            idx_q      <= '0;
            err_q      <= 1'b0;
            busy_q     <= 1'b1;
            reqValid_q <= 1'b1;
            reqAddr_q  <= BASE_ADDR;
`ifdef PIM_META_CSUM_EN
            acc_q       <= '0;
            csumPhase_q <= 1'b0;
`endif
          end
        end
        ST_REQ: begin
          if (metaBus.mem_req_ready) begin
            state_q    <= ST_WAIT;
            reqValid_q <= 1'b0;
          end
        end
        // A response arriving on the timeout's last cycle still wins.
        ST_WAIT: begin
          if (metaBus.mem_rsp_valid) begin
`ifdef PIM_META_CSUM_EN
            if (csumPhase_q) begin
              busy_q <= 1'b0;
              if (metaBus.mem_rsp_data == acc_q) begin
                state_q <= ST_DONE;
                done_q  <= 1'b1;
              end else begin
                state_q <= ST_ERROR;
                err_q   <= 1'b1;
              end
            end else begin
              acc_q    <= acc_q ^ metaBus.mem_rsp_data;
              wrData_q <= metaBus.mem_rsp_data;
              wrEn_q   <= 1'b1;
              state_q  <= ST_WRITE;
            end
`else
            wrData_q <= metaBus.mem_rsp_data;
            wrEn_q   <= 1'b1;
            state_q  <= ST_WRITE;
`endif
          end else if (toExpired) begin
            state_q <= ST_ERROR;
            err_q   <= 1'b1;
            busy_q  <= 1'b0;
          end
        end
        ST_WRITE: begin
          if (idx_q == LAST_IDX) begin
`ifdef PIM_META_CSUM_EN
            csumPhase_q <= 1'b1;
            state_q     <= ST_REQ;
            reqValid_q  <= 1'b1;
            reqAddr_q   <= CSUM_ADDR;
`else
            state_q <= ST_DONE;
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
`endif
          end else begin
            idx_q      <= idx_d;
            state_q    <= ST_REQ;
            reqValid_q <= 1'b1;
            reqAddr_q  <= BASE_ADDR + (ADDR_WIDTH'(idx_d) << 2);
          end
        end
        ST_DONE:  state_q <= ST_IDLE;
        ST_ERROR: state_q <= ST_IDLE;
        default:  state_q <= ST_IDLE;
      endcase
    end
  end

  assign busy_o     = busy_q;
  assign pim_hold_o = busy_q;
  assign done_o     = done_q;
  assign err_o      = err_q;

  assign metaBus.mem_req_valid = reqValid_q;
  assign metaBus.mem_req_addr  = reqAddr_q;
  assign metaBus.meta_wr_en    = wrEn_q;
  assign metaBus.meta_wr_idx   = idx_q;
  assign metaBus.meta_wr_data  = wrData_q;

endmodule
